// File: rtl/game_sequencer.sv
// Game flow sequencer for a frame-based dodge game.
// Tracks lives, score, the post-hit freeze and the object reset pulse.
module game_sequencer #(
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       bright,
    input  logic       player_px,
    input  logic       obs_px,
    output logic       move_en,
    output logic       obj_rst,
    output logic [1:0] state,
    output logic [1:0] lives,
    output logic [9:0] score,
    output logic       flash
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] HIT_INIT   = 8'(HIT_FRAMES);
    localparam logic [9:0] SCORE_MAX  = 10'd1023;

    state_t     cur;
    logic       start_q;
    logic       coll;
    logic [7:0] hit_cnt;
    logic [7:0] hit_dec;
    logic       start_rise;
    logic       frame_coll;

    assign state      = cur;
    assign start_rise = start & ~start_q;
    assign hit_dec    = hit_cnt - 8'd1;
    // An overlap on the tick cycle itself still belongs to the frame ending now.
    assign frame_coll = coll | ((cur == PLAY) & bright & player_px & obs_px);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= IDLE;
            move_en <= 1'b0;
            obj_rst <= 1'b0;
            flash   <= 1'b0;
            lives   <= LIVES_INIT;
            score   <= '0;
            hit_cnt <= '0;
            coll    <= 1'b0;
            // History starts high so a start held through reset is not seen as a press.
            start_q <= 1'b1;
        end else begin
            start_q <= start;
            obj_rst <= 1'b0;
            coll    <= frame_tick ? 1'b0 : frame_coll;

            case (cur)
                IDLE: begin
                    if (start_rise) begin
                        cur     <= PLAY;
                        move_en <= 1'b1;
                        obj_rst <= 1'b1;
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        if (frame_coll) begin
                            lives   <= lives - 2'd1;
                            move_en <= 1'b0;
                            if (lives == 2'd1) begin
                                cur <= OVER;
                            end else begin
                                cur     <= HIT;
                                hit_cnt <= HIT_INIT;
                                flash   <= HIT_INIT[3];
                            end
                        end else if (score != SCORE_MAX) begin
                            score <= score + 10'd1;
                        end
                    end
                end
                HIT: begin
                    if (frame_tick) begin
                        if (hit_cnt == 8'd1) begin
                            cur     <= PLAY;
                            move_en <= 1'b1;
                            obj_rst <= 1'b1;
                            hit_cnt <= '0;
                            flash   <= 1'b0;
                        end else begin
                            hit_cnt <= hit_dec;
                            flash   <= hit_dec[3];
                        end
                    end
                end
                OVER: begin
                    if (start_rise) begin
                        cur   <= IDLE;
                        lives <= LIVES_INIT;
                        score <= '0;
                    end
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed plus randomized check of game_sequencer against a frame-level game model.
module tb_game_sequencer;

    localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_OVER = 3;
    localparam int N_LIVES = 3, N_HIT = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0, start = 1'b0, bright = 1'b0, player_px = 1'b0, obs_px = 1'b0;
    logic       move_en, obj_rst, flash;
    logic [1:0] state, lives;
    logic [9:0] score;

    int vectors = 0;
    int miscompares = 0;

    // Reference game model: phase, counters and the "this frame had a crash" memory.
    int m_state, m_lives, m_score, m_freeze;
    bit m_crashed, m_prev_start, m_move, m_objrst, m_flash;

    game_sequencer #(.LIVES(N_LIVES), .HIT_FRAMES(N_HIT)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .bright(bright),
        .player_px(player_px), .obs_px(obs_px), .move_en(move_en), .obj_rst(obj_rst),
        .state(state), .lives(lives), .score(score), .flash(flash)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_update();
        bit crash, press;
        m_objrst = 1'b0;
        if (rst) begin
            m_state = M_IDLE; m_lives = N_LIVES; m_score = 0; m_freeze = 0;
            m_crashed = 1'b0; m_prev_start = 1'b1;
        end else begin
            crash = m_crashed || (m_state == M_PLAY && bright && player_px && obs_px);
            press = start && !m_prev_start;
            if (m_state == M_IDLE && press) begin
                m_state = M_PLAY; m_objrst = 1'b1;
            end else if (m_state == M_PLAY && frame_tick) begin
                if (crash) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_state = M_OVER;
                    else begin m_state = M_HIT; m_freeze = N_HIT; end
                end else begin
                    m_score = (m_score + 1 > 1023) ? 1023 : m_score + 1;
                end
            end else if (m_state == M_HIT && frame_tick) begin
                m_freeze = m_freeze - 1;
                if (m_freeze == 0) begin m_state = M_PLAY; m_objrst = 1'b1; end
            end else if (m_state == M_OVER && press) begin
                m_state = M_IDLE; m_lives = N_LIVES; m_score = 0;
            end
            m_crashed = frame_tick ? 1'b0 : crash;
            m_prev_start = start;
        end
        m_move  = (m_state == M_PLAY);
        m_flash = (m_state == M_HIT) && ((m_freeze / 8) % 2 == 1);
    endtask

    function automatic logic [31:0] model_vec();
        return {16'd0, 2'(m_state), 2'(m_lives), 10'(m_score), m_move, m_objrst, m_flash};
    endfunction

    task automatic step(input logic t, input logic s, input logic b, input logic p, input logic o);
        frame_tick = t; start = s; bright = b; player_px = p; obs_px = o;
        @(posedge clk);
        model_update();
        #1;
        check("cycle", {16'd0, state, lives, score, move_en, obj_rst, flash}, model_vec());
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit s_level;

        // Reset state
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_score", 32'(score), 32'd0);
        check("rst_outs", {29'd0, move_en, obj_rst, flash}, 32'd0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start a game: obj_rst for exactly one cycle
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("start_state", 32'(state), 32'd1);
        check("start_objrst", 32'(obj_rst), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_objrst_off", 32'(obj_rst), 32'd0);
        check("start_move", 32'(move_en), 32'd1);

        // Clean frames
        tick_n(5);
        check("score5", 32'(score), 32'd5);
        check("lives3", 32'(lives), 32'd3);

        // Overlap in display area, then tick -> HIT
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hit_state", 32'(state), 32'd2);
        check("hit_lives", 32'(lives), 32'd2);
        check("hit_move", 32'(move_en), 32'd0);
        check("hit_flash", 32'(flash), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick_n(59);
        check("hit_59", 32'(state), 32'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hit_exit_state", 32'(state), 32'd1);
        check("hit_exit_objrst", 32'(obj_rst), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hit_exit_objrst_off", 32'(obj_rst), 32'd0);
        check("hit_exit_score", 32'(score), 32'd5);
        check("hit_overlap_ignored", 32'(lives), 32'd2);

        // Overlap outside display area does not count
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("dark_lives", 32'(lives), 32'd2);
        check("dark_score", 32'(score), 32'd6);

        // Overlap on the tick cycle counts
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("tick_overlap_lives", 32'(lives), 32'd1);
        check("tick_overlap_state", 32'(state), 32'd2);
        tick_n(60);
        check("back_to_play", 32'(state), 32'd1);

        // Last life -> OVER; ticks ignored; start returns to IDLE then PLAY
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("over_state", 32'(state), 32'd3);
        check("over_lives", 32'(lives), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("over_score_held", 32'(score), 32'd6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("idle_state", 32'(state), 32'd0);
        check("idle_lives", 32'(lives), 32'd3);
        check("idle_score", 32'(score), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("replay_state", 32'(state), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Score saturation
        tick_n(1030);
        check("score_sat", 32'(score), 32'd1023);

        // Reset mid-HIT with start held
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick_n(3);
        rst = 1'b1;
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("held_start_state", 32'(state), 32'd0);
        check("held_start_lives", 32'(lives), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("repress_state", 32'(state), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized play against the model
        s_level = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 19) == 0) s_level = ~s_level;
            step(1'($urandom_range(0, 3) == 0), s_level, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
